prime_range_scanner: RTL and testbench

PRIME_RANGE_SCANNER -- requirements
Module: prime_range_scanner

---
 rtl/prime_range_scanner.sv | 112 +++++++++++
 tb/tb_prime_range_scanner.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_range_scanner.sv
// Walks an inclusive unsigned range one candidate per cycle, relying on an external
// combinational primality checker, and streams each prime out on a valid/ready port.
module prime_range_scanner #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [31:0]        range_lo,
  input  logic [31:0]        range_hi,
  input  logic               abort,
  output logic [31:0]        cand_num,
  input  logic               cand_is_prime,
  output logic               prime_valid,
  input  logic               prime_ready,
  output logic [31:0]        prime_data,
  output logic [COUNT_W-1:0] prime_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        cur, cur_nxt;
  logic [31:0]        hi, hi_nxt;
  logic [31:0]        data_nxt;
  logic [COUNT_W-1:0] count_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      hi          <= '0;
      prime_data  <= '0;
      prime_count <= '0;
    end else begin
      state       <= state_nxt;
      cur         <= cur_nxt;
      hi          <= hi_nxt;
      prime_data  <= data_nxt;
      prime_count <= count_nxt;
    end
  end

  // Termination tests cur==hi before incrementing so a range ending at all-ones never wraps.
  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    hi_nxt      = hi;
    data_nxt    = prime_data;
    count_nxt   = prime_count;
    start_ready = 1'b0;
    prime_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          cur_nxt   = range_lo;
          hi_nxt    = range_hi;
          count_nxt = '0;
          state_nxt = (range_lo > range_hi) ? FIN : CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = FIN;
        end else if (cand_is_prime) begin
          data_nxt  = cur;
          state_nxt = EMIT;
        end else if (cur == hi) begin
          state_nxt = FIN;
        end else begin
          cur_nxt = cur + 32'd1;
        end
      end
      EMIT: begin
        busy        = 1'b1;
        prime_valid = 1'b1;
        // abort wins over a simultaneous handshake: the prime is dropped, not counted
        if (abort) begin
          state_nxt = FIN;
        end else if (prime_ready) begin
          if (prime_count != '1) count_nxt = prime_count + COUNT_W'(1);
          if (cur == hi) begin
            state_nxt = FIN;
          end else begin
            cur_nxt   = cur + 32'd1;
            state_nxt = CHECK;
          end
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cand_num = cur;

endmodule

// File: tb/tb_prime_range_scanner.sv
// Directed bench for prime_range_scanner; a small primality function plays the checker.
module tb_prime_range_scanner;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [31:0]   range_lo = '0;
  logic [31:0]   range_hi = '0;
  logic          abort = 1'b0;
  logic [31:0]   cand_num;
  logic          cand_is_prime;
  logic          prime_valid;
  logic          prime_ready = 1'b0;
  logic [31:0]   prime_data;
  logic [CW-1:0] prime_count;
  logic          busy;
  logic          done;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  prime_range_scanner #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .range_lo(range_lo), .range_hi(range_hi), .abort(abort), .cand_num(cand_num),
    .cand_is_prime(cand_is_prime), .prime_valid(prime_valid), .prime_ready(prime_ready),
    .prime_data(prime_data), .prime_count(prime_count), .busy(busy), .done(done)
  );

  // Trial division for small values; the only prime in 0xFFFFFFF0..0xFFFFFFFF is 0xFFFFFFFB.
  function automatic logic is_prime(input logic [31:0] n);
    if (n == 32'hFFFF_FFFB) return 1'b1;
    if (n < 32'd2 || n > 32'd1000) return 1'b0;
    for (logic [31:0] d = 32'd2; d * d <= n; d++)
      if (n % d == 32'd0) return 1'b0;
    return 1'b1;
  endfunction

  assign cand_is_prime = is_prime(cand_num);

  // Offer a range for one edge; returns at the negedge of the first cycle after acceptance.
  task automatic start_scan(input logic [31:0] lo, input logic [31:0] hi);
    @(negedge clk);
    start_valid = 1'b1;
    range_lo    = lo;
    range_hi    = hi;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({cand_num, prime_data} !== 64'd0) $display("FAIL reset_data: cand_num=%h prime_data=%h, want 0", cand_num, prime_data);
    else n_pass++;
    n_total++;
    if ({prime_count, prime_valid, busy, done, start_ready} !== {{CW{1'b0}}, 4'b0001})
      $display("FAIL reset_ctrl: count=%0d pv=%b busy=%b done=%b sr=%b, want 0 0 0 0 1", prime_count, prime_valid, busy, done, start_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] got[$];
    logic [31:0] exp_p[4] = '{32'd2, 32'd3, 32'd5, 32'd7};
    int done_cyc = 0;
    int n_done = 0;
    int sr_bad = 0;
    prime_ready = 1'b1;
    start_scan(32'd1, 32'd10);
    n_total++;
    if (cand_num !== 32'd1 || busy !== 1'b1) $display("FAIL basic_first: cand_num=%0d busy=%b, want 1 1", cand_num, busy);
    else n_pass++;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (prime_valid) got.push_back(prime_data);
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (busy && start_ready) sr_bad++;
      // a competing start while busy must be ignored
      if (cyc == 3) begin
        start_valid = 1'b1; range_lo = 32'd50; range_hi = 32'd60;
      end
      if (cyc == 6) start_valid = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (got.size() != 4) $display("FAIL basic_nprimes: got %0d primes, want 4", got.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_total++;
      if (got[i] !== exp_p[i]) $display("FAIL basic_prime%0d: got %0d want %0d", i, got[i], exp_p[i]);
      else n_pass++;
    end
    n_total++;
    if (n_done != 1) $display("FAIL basic_done_count: %0d pulses, want 1", n_done);
    else n_pass++;
    // FIN entered 14 edges after the accepting edge, so done shows in cycle 15
    n_total++;
    if (done_cyc != 15) $display("FAIL basic_latency: done in cycle %0d, want 15", done_cyc);
    else n_pass++;
    n_total++;
    if (prime_count !== 3'd4) $display("FAIL basic_count: got %0d want 4", prime_count);
    else n_pass++;
    n_total++;
    if (sr_bad != 0 || start_ready !== 1'b1) $display("FAIL basic_start_ready: busy-ready cycles=%0d idle sr=%b, want 0 1", sr_bad, start_ready);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [31:0] got[$];
    int hold_bad = 0;
    logic seen_done = 1'b0;
    prime_ready = 1'b0;
    start_scan(32'd2, 32'd3);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (prime_valid !== 1'b1 || prime_data !== 32'd2 || cand_num !== 32'd2) hold_bad++;
      @(negedge clk);
    end
    n_total++;
    if (hold_bad != 0) $display("FAIL bp_hold: %0d of 5 cycles unstable, want 0", hold_bad);
    else n_pass++;
    prime_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
      if (prime_valid) got.push_back(prime_data);
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (!seen_done || got.size() != 2) $display("FAIL bp_stream: done=%b primes=%0d, want 1 2", seen_done, got.size());
    else n_pass++;
    n_total++;
    if (got.size() == 2 && got[1] !== 32'd3) $display("FAIL bp_second: got %0d want 3", got[1]);
    else n_pass++;
    n_total++;
    if (prime_count !== 3'd2) $display("FAIL bp_count: got %0d want 2", prime_count);
    else n_pass++;
  endtask

  task automatic test_top_range;
    logic [31:0] got[$];
    int zero_bad = 0;
    logic seen_done = 1'b0;
    prime_ready = 1'b1;
    start_scan(32'hFFFF_FFF0, 32'hFFFF_FFFF);
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      if (cand_num == 32'd0) zero_bad++;
      if (prime_valid) got.push_back(prime_data);
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    if (cand_num == 32'd0) zero_bad++;
    n_total++;
    if (!seen_done) $display("FAIL top_done: no done within 40 cycles");
    else n_pass++;
    n_total++;
    if (zero_bad != 0) $display("FAIL top_wrap: cand_num was 0 in %0d cycles, want 0", zero_bad);
    else n_pass++;
    n_total++;
    if (got.size() != 1 || got[0] !== 32'hFFFF_FFFB)
      $display("FAIL top_prime: %0d primes first=%h, want 1 fffffffb", got.size(), (got.size() > 0) ? got[0] : 32'd0);
    else n_pass++;
    n_total++;
    if (prime_count !== 3'd1) $display("FAIL top_count: got %0d want 1", prime_count);
    else n_pass++;
  endtask

  task automatic test_abort;
    int waited = 0;
    prime_ready = 1'b0;
    start_scan(32'd1, 32'd10);
    while (!prime_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (prime_valid !== 1'b1 || prime_data !== 32'd2) $display("FAIL abort_emit: pv=%b data=%0d, want 1 2", prime_valid, prime_data);
    else n_pass++;
    abort = 1'b1;
    prime_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    prime_ready = 1'b0;
    n_total++;
    if (done !== 1'b1 || prime_valid !== 1'b0) $display("FAIL abort_fin: done=%b pv=%b, want 1 0", done, prime_valid);
    else n_pass++;
    n_total++;
    if (prime_count !== 3'd0) $display("FAIL abort_count: got %0d want 0", prime_count);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle: sr=%b busy=%b done=%b, want 1 0 0", start_ready, busy, done);
    else n_pass++;
  endtask

  task automatic test_saturate;
    int n_primes = 0;
    logic seen_done = 1'b0;
    prime_ready = 1'b1;
    start_scan(32'd1, 32'd30);
    for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
      if (prime_valid) n_primes++;
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (!seen_done || n_primes != 10) $display("FAIL sat_stream: done=%b primes=%0d, want 1 10", seen_done, n_primes);
    else n_pass++;
    n_total++;
    if (prime_count !== 3'd7) $display("FAIL sat_count: got %0d want 7", prime_count);
    else n_pass++;
  endtask

  // started right after the saturating scan, so the accept must also clear the count
  task automatic test_back_to_back_empty;
    start_scan(32'd20, 32'd10);
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0 || prime_valid !== 1'b0) $display("FAIL empty_done: done=%b busy=%b pv=%b, want 1 0 0", done, busy, prime_valid);
    else n_pass++;
    n_total++;
    if (prime_count !== 3'd0) $display("FAIL empty_count: got %0d want 0", prime_count);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || start_ready !== 1'b1) $display("FAIL empty_idle: done=%b sr=%b, want 0 1", done, start_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int done_bad = 0;
    logic seen_done = 1'b0;
    prime_ready = 1'b1;
    start_scan(32'd1, 32'd100);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({cand_num, prime_data} !== 64'd0 || prime_count !== 3'd0)
      $display("FAIL rstmid_data: cand=%0d data=%0d count=%0d, want 0 0 0", cand_num, prime_data, prime_count);
    else n_pass++;
    n_total++;
    if ({prime_valid, busy, done, start_ready} !== 4'b0001)
      $display("FAIL rstmid_ctrl: pv=%b busy=%b done=%b sr=%b, want 0 0 0 1", prime_valid, busy, done, start_ready);
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      if (done) done_bad++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done) done_bad++;
    n_total++;
    if (done_bad != 0) $display("FAIL rstmid_nodone: %0d done cycles, want 0", done_bad);
    else n_pass++;
    start_scan(32'd2, 32'd3);
    n_total++;
    if (cand_num !== 32'd2 || busy !== 1'b1) $display("FAIL rstmid_restart: cand=%0d busy=%b, want 2 1", cand_num, busy);
    else n_pass++;
    for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (!seen_done || prime_count !== 3'd2) $display("FAIL rstmid_count: done=%b count=%0d, want 1 2", seen_done, prime_count);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_top_range();
    test_abort();
    test_saturate();
    test_back_to_back_empty();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
